// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-organised RAM responder with fixed request-to-response latency
// One request in flight; access is performed on the WAIT->RESP edge, response strobes for one cycle.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] word_idx;

  logic [31:0] mem [DEPTH];

  assign word_idx   = addr_q[ADDR_WIDTH-1:2];
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          // Misaligned accesses never touch memory and return zero data.
          if (addr_q[1:0] != 2'b00) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else if (we_q) begin
            mem_we  = 1'b1;
            rdata_d = wdata_q;
            err_d   = 1'b0;
          end else begin
            rdata_d = mem[word_idx];
            err_d   = 1'b0;
          end
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory is not reset, but a reset on the commit edge must still suppress the write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[word_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
// Main instance at LATENCY=2; two extra instances measure LATENCY=1 and LATENCY=16.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        l_valid  [2];
  logic        l_ready  [2];
  logic        l_we     [2];
  logic [7:0]  l_addr   [2];
  logic [31:0] l_wdata  [2];
  logic        l_rvalid [2];
  logic [31:0] l_rdata  [2];
  logic        l_err    [2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mm [int];
  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  int          last_acc = -1;
  logic        prev_valid = 1'b0;
  logic [31:0] last_rdata;
  logic        last_err;

  mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .req_valid(l_valid[0]), .req_ready(l_ready[0]),
    .req_we(l_we[0]), .req_addr(l_addr[0]), .req_wdata(l_wdata[0]),
    .resp_valid(l_rvalid[0]), .resp_rdata(l_rdata[0]), .resp_err(l_err[0])
  );

  mem_responder #(.ADDR_WIDTH(8), .LATENCY(16)) u_dut_l16 (
    .clk(clk), .reset(reset), .req_valid(l_valid[1]), .req_ready(l_ready[1]),
    .req_we(l_we[1]), .req_addr(l_addr[1]), .req_wdata(l_wdata[1]),
    .resp_valid(l_rvalid[1]), .resp_rdata(l_rdata[1]), .resp_err(l_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid === 1'b1) begin
      chk("resp_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_latency", 32'(cycle), 32'(e.due));
      end
    end else if (prev_valid && !reset) begin
      chk("rdata_hold", resp_rdata, last_rdata);
      chk("err_hold", {31'd0, resp_err}, {31'd0, last_err});
    end
    prev_valid = (resp_valid === 1'b1);
    last_rdata = resp_rdata;
    last_err   = resp_err;
  end

  // Issue one request starting at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                       input bit push, input bit btb);
    bit   ok;
    int   acc;
    exp_t e;
    ok        = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    acc = cycle + 1;
    if (btb) chk("accept_spacing", 32'(acc - last_acc), 32'(LAT + 2));
    last_acc = acc;
    if (push) begin
      e.due = acc + LAT;
      if (addr[1:0] != 2'b00) begin
        e.rdata = 32'd0;
        e.err   = 1'b1;
      end else if (we) begin
        mm[int'(addr >> 2)] = wd;
        e.rdata = wd;
        e.err   = 1'b0;
      end else begin
        e.rdata = mm[int'(addr >> 2)];
        e.err   = 1'b0;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drop valid, scribble on the other inputs, and wait for the response to drain.
  task automatic drain();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = $urandom;
    for (int i = 0; i < 40; i++) begin
      if (req_ready === 1'b1 && exp_q.size() == 0) return;
      @(negedge clk);
    end
    chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic abort_write(input int delay);
    issue(1'b1, 8'h20, 32'hA5A5A5A5, 0, 0);
    req_valid = 1'b0;
    repeat (delay) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    repeat (LAT + 3) @(negedge clk);
    issue(1'b0, 8'h20, 32'd0, 1, 0);
    drain();
  endtask

  task automatic lat_test(input int k, input int lat);
    int          n;
    logic [31:0] wd;
    wd = $urandom;
    l_valid[k] = 1'b1;
    l_we[k]    = 1'b1;
    l_addr[k]  = 8'h0C;
    l_wdata[k] = wd;
    chk("lat_ready", {31'd0, l_ready[k]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    l_valid[k] = 1'b0;
    n = 0;
    while (l_rvalid[k] !== 1'b1 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("lat_edges", 32'(n), 32'(lat));
    chk("lat_rdata", l_rdata[k], wd);
    chk("lat_err", {31'd0, l_err[k]}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic        we;
    logic [7:0]  a;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'd0;
    req_wdata = 32'd0;
    for (int k = 0; k < 2; k++) begin
      l_valid[k] = 1'b0;
      l_we[k]    = 1'b0;
      l_addr[k]  = 8'd0;
      l_wdata[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, req_ready}, 32'd1);
      chk("idle_valid", {31'd0, resp_valid}, 32'd0);
      chk("idle_rdata", resp_rdata, 32'd0);
      chk("idle_err", {31'd0, resp_err}, 32'd0);
    end

    issue(1'b1, 8'h10, 32'hDEADBEEF, 1, 0);
    req_valid = 1'b0;
    chk("e0_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("e1_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("e2_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("e3_ready", {31'd0, req_ready}, 32'd1);
    drain();
    issue(1'b0, 8'h10, 32'd0, 1, 0);
    drain();

    issue(1'b0, 8'h13, 32'd0, 1, 0);
    drain();
    issue(1'b1, 8'h11, 32'h12345678, 1, 0);
    drain();
    issue(1'b0, 8'h10, 32'd0, 1, 0);
    drain();

    issue(1'b1, 8'h08, $urandom, 1, 0);
    drain();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) issue(1'b1, 8'h04, $urandom, 1, i > 0);
      else            issue(1'b0, 8'h08, 32'd0, 1, 1);
    end
    drain();

    issue(1'b1, 8'h20, 32'h11223344, 1, 0);
    drain();
    abort_write(0);
    abort_write(1);

    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom);
      a  = 8'($urandom_range(0, 63));
      if (a[1:0] == 2'b00 && !we && !mm.exists(int'(a >> 2))) we = 1'b1;
      issue(we, a, $urandom, 1, 0);
      if ($urandom_range(0, 2) != 0) drain();
    end
    drain();

    lat_test(0, 1);
    lat_test(1, 16);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
